// File: rtl/rr_grant_scheduler_pkg.sv
// Shared constants, FSM encoding and helpers for the round-robin grant scheduler.
package rr_grant_scheduler_pkg;

  localparam int RR_NUM_REQ      = 4;
  localparam int RR_ID_W         = 2;
  localparam int RR_MAX_HOLD_DEF = 16;
  localparam int RR_HOLD_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  function automatic logic [RR_NUM_REQ-1:0] id_to_onehot(input logic [RR_ID_W-1:0] id);
    id_to_onehot = {{(RR_NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/release inputs and grant outputs of the scheduler, bundled for port use.
interface rr_grant_scheduler_if;
  import rr_grant_scheduler_pkg::*;

  logic [RR_NUM_REQ-1:0] req;
  logic [RR_NUM_REQ-1:0] done;
  logic [RR_NUM_REQ-1:0] gnt;
  logic                  gnt_valid;
  logic [RR_ID_W-1:0]    gnt_id;
  logic                  timeout;

  modport master (output req, done, input gnt, gnt_valid, gnt_id, timeout);
  modport slave  (input req, done, output gnt, gnt_valid, gnt_id, timeout);

endinterface

// File: rtl/rr_grant_scheduler_pick.sv
// Combinational rotating-priority search: first set request at or above ptr, modulo 4.
module rr_pick
  import rr_grant_scheduler_pkg::*;
(
  input  logic [RR_NUM_REQ-1:0] req_i,
  input  logic [RR_ID_W-1:0]    ptr_i,
  output logic                  pick_valid_o,
  output logic [RR_ID_W-1:0]    pick_id_o
);

  logic [RR_ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester above ptr wins.
  always_comb begin
    pick_valid_o = 1'b0;
    pick_id_o    = 2'd0;
    idx          = 2'd0;
    for (int i = RR_NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr_i + 2'(i);
      if (req_i[idx]) begin
        pick_valid_o = 1'b1;
        pick_id_o    = idx;
      end else begin
        pick_valid_o = pick_valid_o;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler with bounded ownership, one-cycle turnaround and timeout pulse.
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = RR_NUM_REQ,
  parameter int MAX_HOLD = RR_MAX_HOLD_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  rr_grant_scheduler_if.slave  bus
);

  localparam logic [RR_HOLD_W-1:0] HOLD_LAST = RR_HOLD_W'(MAX_HOLD - 1);

  state_e                 state_q, state_d;
  logic [RR_ID_W-1:0]     owner_q, owner_d;
  logic [RR_ID_W-1:0]     ptr_q, ptr_d;
  logic [RR_HOLD_W-1:0]   hold_q, hold_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic                   gnt_valid_q, gnt_valid_d;
  logic [RR_ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic                   timeout_q, timeout_d;

  logic                   pick_valid;
  logic [RR_ID_W-1:0]     pick_id;
  logic                   rel_done, rel_drop, rel_max;

  rr_pick u_pick (
    .req_i        (bus.req),
    .ptr_i        (ptr_q),
    .pick_valid_o (pick_valid),
    .pick_id_o    (pick_id)
  );

  // Next-state and registered-output decode; outputs default to the no-owner pattern.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = {NUM_REQ{1'b0}};
    gnt_valid_d = 1'b0;
    gnt_id_d    = 2'd0;
    timeout_d   = 1'b0;
    rel_done    = bus.done[owner_q];
    rel_drop    = ~bus.req[owner_q];
    rel_max     = (hold_q == HOLD_LAST);
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_GRANT;
          owner_d     = pick_id;
          hold_d      = {RR_HOLD_W{1'b0}};
          gnt_d       = id_to_onehot(pick_id);
          gnt_valid_d = 1'b1;
          gnt_id_d    = pick_id;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (rel_done || rel_drop || rel_max) begin
          state_d   = ST_TURN;
          ptr_d     = owner_q + 2'd1;
          // A coincident done or request drop makes the release normal, not a timeout.
          timeout_d = rel_max & ~rel_done & ~rel_drop;
        end else begin
          hold_d      = hold_q + RR_HOLD_W'(1);
          gnt_d       = gnt_q;
          gnt_valid_d = 1'b1;
          gnt_id_d    = owner_q;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd0;
      hold_q      <= {RR_HOLD_W{1'b0}};
      gnt_q       <= {NUM_REQ{1'b0}};
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 2'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scenario-driven bench: each row drives req/done/reset and queues the expected registered outputs.
module tb_rr_grant_scheduler;
  import rr_grant_scheduler_pkg::*;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] egnt;
    logic       etmo;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  row_t       stim_q[$];
  logic [7:0] exp_q[$];

  rr_grant_scheduler_if bus_if ();

  rr_grant_scheduler dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // Expected {gnt, gnt_valid, gnt_id, timeout} for a given grant vector and timeout bit.
  function automatic logic [7:0] exp_vec(input logic [3:0] g, input logic t);
    logic [1:0] id;
    case (g)
      4'b0010: id = 2'd1;
      4'b0100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = 2'd0;
    endcase
    return {g, (g != 4'b0000), id, t};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {bus_if.gnt, bus_if.gnt_valid, bus_if.gnt_id, bus_if.timeout};
  endfunction

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                     input logic [3:0] g, input logic t);
    row_t s;
    s.rst  = r;
    s.req  = rq;
    s.done = dn;
    s.egnt = g;
    s.etmo = t;
    stim_q.push_back(s);
  endtask

  task automatic step_row();
    row_t s;
    s = stim_q.pop_front();
    rst         = s.rst;
    bus_if.req  = s.req;
    bus_if.done = s.done;
    exp_q.push_back(exp_vec(s.egnt, s.etmo));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] e;
    n = 0;
    add(1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0);
    add(1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0);
    add(1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    while (stim_q.size() > 0) begin
      step_row();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL reset row %0d: gnt/vld/id/tmo got %b want %b", n, obs_vec(), e);
      end
      n++;
    end
  endtask

  task automatic test_rotation();
    int n;
    logic [7:0] e;
    logic [3:0] g;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      add(1'b0, 4'b1111, 4'b0000, g, 1'b0);
      add(1'b0, 4'b1111, 4'b0000, g, 1'b0);
      add(1'b0, 4'b1111, 4'b0000, g, 1'b0);
      add(1'b0, 4'b1111, g, 4'b0000, 1'b0);
      add(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    end
    while (stim_q.size() > 0) begin
      step_row();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL rotation row %0d: gnt/vld/id/tmo got %b want %b", n, obs_vec(), e);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [7:0] e;
    n = 0;
    add(1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 16; k++) add(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0);
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0);
    while (stim_q.size() > 0) begin
      step_row();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL timeout row %0d: gnt/vld/id/tmo got %b want %b", n, obs_vec(), e);
      end
      n++;
    end
  endtask

  task automatic test_req_drop();
    int n;
    logic [7:0] e;
    n = 0;
    add(1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 4'b1010, 4'b0000, 4'b0010, 1'b0);
    add(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0);
    while (stim_q.size() > 0) begin
      step_row();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL req_drop row %0d: gnt/vld/id/tmo got %b want %b", n, obs_vec(), e);
      end
      n++;
    end
  endtask

  task automatic test_done_at_max();
    int n;
    logic [7:0] e;
    n = 0;
    add(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 16; k++) add(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    add(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    add(1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b0011, 4'b0000, 4'b0010, 1'b0);
    while (stim_q.size() > 0) begin
      step_row();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL done_at_max row %0d: gnt/vld/id/tmo got %b want %b", n, obs_vec(), e);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_grant();
    int n;
    logic [7:0] e;
    n = 0;
    add(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    add(1'b0, 4'b0001, 4'b0100, 4'b0001, 1'b0);
    add(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    add(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    add(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b1010, 4'b0000, 4'b0010, 1'b0);
    while (stim_q.size() > 0) begin
      step_row();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL reset_mid_grant row %0d: gnt/vld/id/tmo got %b want %b", n, obs_vec(), e);
      end
      n++;
    end
  endtask

  task automatic test_ptr_wrap();
    int n;
    logic [7:0] e;
    n = 0;
    add(1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0);
    add(1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b0);
    while (stim_q.size() > 0) begin
      step_row();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL ptr_wrap row %0d: gnt/vld/id/tmo got %b want %b", n, obs_vec(), e);
      end
      n++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus_if.req  = 4'b0000;
    bus_if.done = 4'b0000;
    test_reset();
    test_rotation();
    test_timeout();
    test_req_drop();
    test_done_at_max();
    test_reset_mid_grant();
    test_ptr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
